// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one DMEM port between the core (C) and a loader/DMA port (D).
// Supports bounded lock bursts, one-cycle read return and a saturating core-stall counter.
module dmem_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_c_req,
  input  logic              i_c_we,
  input  logic              i_c_lock,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [DATA_W-1:0] i_c_wdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic              i_d_lock,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_c_gnt,
  output logic              o_d_gnt,
  output logic              o_c_rvalid,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_c_rdata,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_core_stall,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_C = 2'd1,
    ST_OWN_D = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_last_d;
  logic               w_last_d_next;
  logic [BURST_W-1:0] r_burst_cnt;
  logic [BURST_W-1:0] w_burst_next;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic w_c_gnt;
  logic w_d_gnt;
  logic w_c_access;
  logic w_d_access;
  logic w_core_stall;
  logic w_burst_room;

  assign w_c_gnt      = (r_state == ST_OWN_C);
  assign w_d_gnt      = (r_state == ST_OWN_D);
  assign w_c_access   = w_c_gnt & i_c_req;
  assign w_d_access   = w_d_gnt & i_d_req;
  assign w_core_stall = i_c_req & ~w_c_gnt;
  assign w_burst_room = (r_burst_cnt < BURST_LAST);

  assign o_c_gnt      = w_c_gnt;
  assign o_d_gnt      = w_d_gnt;
  assign o_core_stall = w_core_stall;
  assign o_stall_cnt  = r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_last_d    <= 1'b1;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_last_d    <= w_last_d_next;
      r_burst_cnt <= w_burst_next;
    end
  end

  // last_owner only changes when an owner actually gives up the port.
  always_comb begin
    w_state_next  = r_state;
    w_last_d_next = r_last_d;
    w_burst_next  = r_burst_cnt;
    case (r_state)
      ST_IDLE: begin
        w_burst_next = '0;
        if (i_c_req && i_d_req) begin
          w_state_next = r_last_d ? ST_OWN_C : ST_OWN_D;
        end else if (i_c_req) begin
          w_state_next = ST_OWN_C;
        end else if (i_d_req) begin
          w_state_next = ST_OWN_D;
        end
      end
      ST_OWN_C: begin
        if (i_c_req && i_c_lock && w_burst_room) begin
          w_burst_next = r_burst_cnt + BURST_W'(1);
        end else if (i_d_req) begin
          w_state_next  = ST_OWN_D;
          w_burst_next  = '0;
          w_last_d_next = 1'b0;
        end else if (i_c_req) begin
          w_burst_next = '0;
        end else begin
          w_state_next  = ST_IDLE;
          w_burst_next  = '0;
          w_last_d_next = 1'b0;
        end
      end
      ST_OWN_D: begin
        if (i_d_req && i_d_lock && w_burst_room) begin
          w_burst_next = r_burst_cnt + BURST_W'(1);
        end else if (i_c_req) begin
          w_state_next  = ST_OWN_C;
          w_burst_next  = '0;
          w_last_d_next = 1'b1;
        end else if (i_d_req) begin
          w_burst_next = '0;
        end else begin
          w_state_next  = ST_IDLE;
          w_burst_next  = '0;
          w_last_d_next = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_burst_next = '0;
      end
    endcase
  end

  // Memory port is driven only in a true access cycle; reset clears the grant
  // asynchronously, so enables drop as soon as reset asserts.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_we    = 1'b0;
    o_mem_re    = 1'b0;
    if (w_c_access) begin
      o_mem_addr  = i_c_addr;
      o_mem_wdata = i_c_wdata;
      o_mem_we    = i_c_we;
      o_mem_re    = ~i_c_we;
    end else if (w_d_access) begin
      o_mem_addr  = i_d_addr;
      o_mem_wdata = i_d_wdata;
      o_mem_we    = i_d_we;
      o_mem_re    = ~i_d_we;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_core_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Per-requester read return path: index 0 is C, index 1 is D.
  logic [1:0] w_rd_access;
  assign w_rd_access[0] = w_c_access & ~i_c_we;
  assign w_rd_access[1] = w_d_access & ~i_d_we;

  for (genvar gi = 0; gi < 2; gi++) begin : gen_ret
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
      end else begin
        r_rvalid <= w_rd_access[gi];
        if (w_rd_access[gi]) begin
          r_rdata <= i_mem_rdata;
        end
      end
    end

    if (gi == 0) begin : gen_c
      assign o_c_rvalid = r_rvalid;
      assign o_c_rdata  = r_rdata;
    end else begin : gen_d
      assign o_d_rvalid = r_rvalid;
      assign o_d_rdata  = r_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a simple DMEM model; a second instance uses a 4-bit stall counter.
module tb_dmem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          c_req, c_we, c_lock, d_req, d_we, d_lock;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic          c_gnt, d_gnt, c_rvalid, d_rvalid, core_stall, mem_we, mem_re;
  logic [DW-1:0] c_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   stall_cnt;

  logic          s_c_req, s_d_req, s_zero;
  logic [AW-1:0] s_addr0;
  logic [DW-1:0] s_data0;
  logic          s_c_gnt, s_d_gnt, s_c_rvalid, s_d_rvalid, s_core_stall, s_mem_we, s_mem_re;
  logic [DW-1:0] s_c_rdata, s_d_rdata, s_mem_wdata;
  logic [AW-1:0] s_mem_addr;
  logic [3:0]    s_stall_cnt;

  logic [63:0] dmem [0:63];
  int wr_count = 0;
  int errors = 0;
  int checks = 0;

  assign mem_rdata = dmem[mem_addr[8:3]];
  always @(posedge clk) begin
    if (mem_we) begin
      dmem[mem_addr[8:3]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  dmem_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_lock(c_lock), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_lock(d_lock), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_c_gnt(c_gnt), .o_d_gnt(d_gnt), .o_c_rvalid(c_rvalid), .o_d_rvalid(d_rvalid),
    .o_c_rdata(c_rdata), .o_d_rdata(d_rdata), .o_core_stall(core_stall), .o_stall_cnt(stall_cnt),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we), .o_mem_re(mem_re),
    .i_mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_c_req(s_c_req), .i_c_we(s_zero), .i_c_lock(s_zero), .i_c_addr(s_addr0), .i_c_wdata(s_data0),
    .i_d_req(s_d_req), .i_d_we(s_zero), .i_d_lock(s_zero), .i_d_addr(s_addr0), .i_d_wdata(s_data0),
    .o_c_gnt(s_c_gnt), .o_d_gnt(s_d_gnt), .o_c_rvalid(s_c_rvalid), .o_d_rvalid(s_d_rvalid),
    .o_c_rdata(s_c_rdata), .o_d_rdata(s_d_rdata), .o_core_stall(s_core_stall), .o_stall_cnt(s_stall_cnt),
    .o_mem_addr(s_mem_addr), .o_mem_wdata(s_mem_wdata), .o_mem_we(s_mem_we), .o_mem_re(s_mem_re),
    .i_mem_rdata(s_data0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    c_req = 0; c_we = 0; c_lock = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
    s_c_req = 0; s_d_req = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (c_gnt !== 1'b0) begin errors++; $display("FAIL reset_c_gnt: got %b want 0", c_gnt); end
    checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL reset_d_gnt: got %b want 0", d_gnt); end
    checks++; if ({c_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b%b want 00", c_rvalid, d_rvalid); end
    checks++; if (c_rdata !== 64'd0) begin errors++; $display("FAIL reset_c_rdata: got %h want 0", c_rdata); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    checks++; if ({mem_we, mem_re} !== 2'b00) begin errors++; $display("FAIL reset_mem_en: got %b%b want 00", mem_we, mem_re); end
    rst_n = 1;
    tick();
    $display("reset: released");
  endtask

  task automatic test_c_write();
    c_req = 1; c_we = 1; c_addr = 64'd0; c_wdata = 64'd8;
    @(negedge clk);
    checks++; if (c_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt_early: got %b want 0", c_gnt); end
    checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL wr_stall: got %b want 1", core_stall); end
    tick();
    @(negedge clk);
    checks++; if (c_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", c_gnt); end
    checks++; if ({mem_we, mem_re} !== 2'b10) begin errors++; $display("FAIL wr_mem_en: got %b%b want 10", mem_we, mem_re); end
    checks++; if (mem_wdata !== 64'd8 || mem_addr !== 64'd0) begin errors++; $display("FAIL wr_mem_bus: got addr %h data %h want 0/8", mem_addr, mem_wdata); end
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL wr_stall_off: got %b want 0", core_stall); end
    tick();
    c_req = 0; c_we = 0;
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_we_once: got %b want 0", mem_we); end
    checks++; if (dmem[0] !== 64'd8) begin errors++; $display("FAIL wr_dmem0: got %h want 8", dmem[0]); end
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL wr_stall_cnt: got %0d want 1", stall_cnt); end
    tick();
    $display("C write: addr 0 data 8");
  endtask

  task automatic test_c_read();
    c_req = 1; c_we = 0; c_addr = 64'd0;
    @(negedge clk);
    checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL rd_stall: got %b want 1", core_stall); end
    tick();
    @(negedge clk);
    checks++; if ({c_gnt, mem_re, mem_we} !== 3'b110) begin errors++; $display("FAIL rd_access: got gnt/re/we %b%b%b want 110", c_gnt, mem_re, mem_we); end
    checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_early: got %b want 0", c_rvalid); end
    tick();
    c_req = 0;
    @(negedge clk);
    checks++; if (c_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b want 1", c_rvalid); end
    checks++; if (c_rdata !== 64'd8) begin errors++; $display("FAIL rd_rdata: got %h want 8", c_rdata); end
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL rd_d_rvalid: got %b want 0", d_rvalid); end
    tick();
    @(negedge clk);
    checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL rd_pulse: got %b want 0", c_rvalid); end
    checks++; if (c_rdata !== 64'd8) begin errors++; $display("FAIL rd_hold: got %h want 8", c_rdata); end
    checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL rd_stall_cnt: got %0d want 2", stall_cnt); end
    tick();
    $display("C read: addr 0 data %h", c_rdata);
  endtask

  task automatic test_alternate();
    logic exp_c, exp_d, exp_cv, exp_dv;
    do_reset();
    c_req = 1; c_we = 0; c_addr = 64'd0;
    d_req = 1; d_we = 0; d_addr = 64'd8;
    for (int k = 0; k < 9; k++) begin
      exp_c  = (k % 2 == 1);
      exp_d  = (k >= 2) && (k % 2 == 0);
      exp_cv = (k >= 2) && (k % 2 == 0);
      exp_dv = (k >= 3) && (k % 2 == 1);
      @(negedge clk);
      checks++; if ({c_gnt, d_gnt} !== {exp_c, exp_d}) begin errors++; $display("FAIL alt_gnt[%0d]: got %b%b want %b%b", k, c_gnt, d_gnt, exp_c, exp_d); end
      checks++; if (stall_cnt !== 32'((k + 1) / 2)) begin errors++; $display("FAIL alt_stall_cnt[%0d]: got %0d want %0d", k, stall_cnt, (k + 1) / 2); end
      checks++; if ({c_rvalid, d_rvalid} !== {exp_cv, exp_dv}) begin errors++; $display("FAIL alt_rvalid[%0d]: got %b%b want %b%b", k, c_rvalid, d_rvalid, exp_cv, exp_dv); end
      if (exp_cv) begin
        checks++; if (c_rdata !== 64'd8) begin errors++; $display("FAIL alt_c_rdata[%0d]: got %h want 8", k, c_rdata); end
      end
      if (exp_dv) begin
        checks++; if (d_rdata !== 64'hD1) begin errors++; $display("FAIL alt_d_rdata[%0d]: got %h want d1", k, d_rdata); end
      end
      $display("alternate cycle %0d: c_gnt=%b d_gnt=%b", k, c_gnt, d_gnt);
      tick();
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_lock_burst();
    int  di;
    logic c_done, exp_c, exp_d, exp_we, exp_st;
    do_reset();
    di = 0;
    c_done = 0;
    for (int k = 0; k < 10; k++) begin
      d_lock = 1; d_we = 1;
      d_req   = (di < 6);
      d_addr  = 64'(di * 8);
      d_wdata = 64'h100 + 64'(di);
      c_req   = (k >= 1) && !c_done;
      c_we = 0; c_addr = 64'd0;
      exp_d  = (k >= 1 && k <= 4) || (k >= 6 && k <= 8);
      exp_c  = (k == 5);
      exp_we = exp_d && (k <= 7);
      exp_st = (k >= 1 && k <= 4);
      @(negedge clk);
      checks++; if ({c_gnt, d_gnt} !== {exp_c, exp_d}) begin errors++; $display("FAIL lock_gnt[%0d]: got %b%b want %b%b", k, c_gnt, d_gnt, exp_c, exp_d); end
      checks++; if (mem_we !== exp_we) begin errors++; $display("FAIL lock_we[%0d]: got %b want %b", k, mem_we, exp_we); end
      checks++; if (core_stall !== exp_st) begin errors++; $display("FAIL lock_stall[%0d]: got %b want %b", k, core_stall, exp_st); end
      if (k == 6) begin
        checks++; if (c_rvalid !== 1'b1 || c_rdata !== 64'h100) begin errors++; $display("FAIL lock_c_read: got v=%b d=%h want 1/100", c_rvalid, c_rdata); end
      end
      $display("lock cycle %0d: c_gnt=%b d_gnt=%b we=%b addr=%h", k, c_gnt, d_gnt, mem_we, mem_addr);
      if (d_gnt && d_req) di++;
      if (c_gnt && c_req) c_done = 1;
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      checks++; if (dmem[i] !== 64'h100 + 64'(i)) begin errors++; $display("FAIL lock_dmem[%0d]: got %h want %h", i, dmem[i], 64'h100 + 64'(i)); end
    end
    checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL lock_stall_cnt: got %0d want 4", stall_cnt); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int wc;
    do_reset();
    d_req = 1; d_lock = 1; d_we = 1; d_addr = 64'h30; d_wdata = 64'hAA;
    tick();
    @(negedge clk);
    checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL mid_first: got gnt=%b we=%b want 1/1", d_gnt, mem_we); end
    tick();
    d_addr = 64'h38; d_wdata = 64'hBB;
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    checks++; if ({d_gnt, mem_we, mem_re, d_rvalid} !== 4'b0000) begin errors++; $display("FAIL mid_async: got gnt/we/re/rv %b%b%b%b want 0000", d_gnt, mem_we, mem_re, d_rvalid); end
    wc = wr_count;
    tick();
    checks++; if (wr_count !== wc || dmem[7] !== 64'd0) begin errors++; $display("FAIL mid_no_write: got writes %0d->%0d dmem7=%h want none", wc, wr_count, dmem[7]); end
    checks++; if (dmem[6] !== 64'hAA) begin errors++; $display("FAIL mid_prior_write: got %h want aa", dmem[6]); end
    c_req = 1; c_we = 0; c_addr = 64'd0; d_lock = 0;
    @(negedge clk);
    rst_n = 1;
    tick();
    @(negedge clk);
    checks++; if ({c_gnt, d_gnt} !== 2'b10) begin errors++; $display("FAIL mid_tie_c: got %b%b want 10", c_gnt, d_gnt); end
    $display("reset mid-burst: write count %0d, first grant c=%b", wr_count, c_gnt);
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_stall_saturation();
    int nst;
    do_reset();
    s_c_req = 1; s_d_req = 1;
    nst = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++; if (s_stall_cnt !== 4'((nst > 15) ? 15 : nst)) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, s_stall_cnt, (nst > 15) ? 15 : nst); end
      if (s_core_stall) nst++;
      tick();
    end
    @(negedge clk);
    checks++; if (nst !== 20) begin errors++; $display("FAIL sat_stall_cycles: got %0d want 20", nst); end
    checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_final: got %0d want 15", s_stall_cnt); end
    $display("stall saturation: %0d stall cycles, counter %0d", nst, s_stall_cnt);
    clear_inputs();
  endtask

  initial begin
    s_zero = 0; s_addr0 = '0; s_data0 = '0;
    clear_inputs();
    rst_n = 0;
    for (int i = 0; i < 64; i++) dmem[i] = 64'd0;
    dmem[1] = 64'hD1;
    test_reset();
    test_c_write();
    test_c_read();
    test_alternate();
    test_lock_burst();
    test_reset_mid_burst();
    test_stall_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the 64-bit data memory.
- Shares the single DMEM port between the riscV core data port (requester C) and a program/data loader or DMA port (requester D).
- Arbitration is round-robin with optional bounded lock bursts; read data returns one cycle after the access cycle.
- Generates a stall signal for the core and a saturating stall-cycle counter for performance checks.

Parameters:
- ADDR_W, 64, address width (byte address; memory word index = addr[ADDR_W-1:3]).
- DATA_W, 64, data width.
- MAX_BURST, 4, maximum consecutive locked accesses by one owner before a forced release (≥1).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- c_req / d_req  in  1  access request; addr, we and wdata are held stable until the granted cycle.
- c_we / d_we  in  1  1 = write, 0 = read.
- c_lock / d_lock  in  1  keep ownership for the next access (burst).
- c_addr / d_addr  in  ADDR_W  byte address.
- c_wdata / d_wdata  in  DATA_W  write data.
- c_gnt / d_gnt  out  1  registered; owner of the memory port this cycle.
- c_rvalid / d_rvalid  out  1  registered read-data valid.
- c_rdata / d_rdata  out  DATA_W  registered read data.
- core_stall  out  1  c_req & ~c_gnt (combinational).
- stall_cnt  out  CNT_W  saturating count of cycles with core_stall=1.
- mem_addr  out  ADDR_W  to DMEM.
- mem_wdata  out  DATA_W  to DMEM.
- mem_we  out  1  DMEM write enable (MemWrite).
- mem_re  out  1  DMEM read enable (MemRead).
- mem_rdata  in  DATA_W  combinational read data from DMEM.

Behaviour:
- FSM states: IDLE, OWN_C, OWN_D. c_gnt = (state==OWN_C); d_gnt = (state==OWN_D). Grants are Moore decodes.
- Reset (rst=0, async): state=IDLE, last_owner=D (so C wins the first tie), burst_cnt=0, all gnt=0, rvalid=0, rdata=0, stall_cnt=0.
- Access cycle: state==OWN_x and x_req=1.
  - mem_addr, mem_wdata = x's inputs.
  - mem_we = x_we; mem_re = ~x_we.
  - In all other cycles mem_we = mem_re = 0, and mem_addr / mem_wdata = 0.
- Read return: x_rvalid=1 and x_rdata=mem_rdata in the cycle after a read access cycle. x_rdata holds its value otherwise. rvalid is a single-cycle pulse per read.
- Latency: request raised in IDLE at cycle N gives grant at N+1. Back-to-back accesses by the same owner are 1 per cycle.
- IDLE next state:
  - Both requesting: the owner ≠ last_owner.
  - Only one requesting: that requester.
  - Neither: IDLE.
  - burst_cnt=0 on entry to a new owner.
- OWN_x next state, evaluated at end of cycle; y is the other requester:
  - x_req & x_lock & burst_cnt<MAX_BURST-1: stay, burst_cnt++.
  - Else if y_req: OWN_y, burst_cnt=0, last_owner=x.
  - Else if x_req: stay, burst_cnt=0.
  - Else: IDLE, last_owner=x.
- Lock is ignored once MAX_BURST consecutive accesses complete, so the other requester is guaranteed a grant within MAX_BURST+1 cycles.
- Owner drops req while granted: no memory access; release per the rules above.
- stall_cnt increments each cycle core_stall=1 and saturates at all-ones.
- Reset mid-burst: grant drops immediately and mem_we/mem_re go low asynchronously, so no write completes after rst falls. Any pending rvalid is cleared.
- MAX_BURST=1: lock has no effect; strict alternation under contention.

Test Plan:
- Reset release, C writes 64'd8 to addr 0: c_gnt rises 1 cycle after c_req, mem_we=1 for one cycle, DMEM[0]=8, core_stall=1 for exactly 1 cycle, stall_cnt=1.
- C reads addr 0 after the write: c_rvalid pulses the cycle after the access with c_rdata=8; d_rvalid stays 0.
- C and D both request continuously, no lock, from reset: grants alternate C,D,C,D… starting with C, one access per cycle each turn; stall_cnt increments on every D-owned cycle.
- D holds d_lock=1 with 6 back-to-back writes (addr 0x00..0x28) while C requests, MAX_BURST=4: D gets 4 consecutive accesses, C gets the next cycle, then D resumes; C waits exactly 4 cycles.
- rst driven low mid-way through a D write burst: d_gnt, mem_we and d_rvalid go 0 within the same cycle with no further DMEM updates; after release the next request is granted to C on a tie.
- Force stall_cnt near saturation (CNT_W=4, 20 stall cycles): the counter stops at 15 with no wrap.
